// File: rtl/mem_byte_sequencer_pkg.sv
// Shared types for the byte-serial data memory sequencer:
// access size encodings, FSM states and the size-to-byte-count helper.
package mem_seq_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } state_t;

    // Illegal sizes map to 1 so range arithmetic stays well-defined.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_HALF: n = 3'd2;
            SIZE_WORD: n = 3'd4;
            default:   n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// LSU request/response handshake plus the byte-wide memory port,
// seen from the requester/memory side (master) and the sequencer (slave).
interface mem_byte_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic [7:0]            mem_rdata;

    modport master (
        output req_valid, req_we, req_size,
        output req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_size,
        input  req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, rsp_valid, rsp_rdata,
        output rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_load_extend.sv
// Sign/zero extension of the assembled little-endian load lanes.
module mem_load_extend
    import mem_seq_pkg::*;
(
    input  logic [31:0] lanes,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata
);
    logic sb, sh;

    assign sb = ~uns & lanes[7];
    assign sh = ~uns & lanes[15];

    always_comb begin
        rdata = lanes;
        unique case (1'b1)
            size == SIZE_BYTE: rdata = {{24{sb}}, lanes[7:0]};
            size == SIZE_HALF: rdata = {{16{sh}}, lanes[15:0]};
            default:           rdata = lanes;
        endcase
    end
endmodule

// File: rtl/mem_byte_sequencer.sv
// Splits LSU byte/half/word accesses into consecutive byte accesses
// on a 1-cycle-latency byte memory; assembles and extends load data.
module mem_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 11
) (
    input logic                 clk,
    input logic                 rst,
    mem_byte_sequencer_if.slave bus
);
    localparam int AW1 = ADDR_WIDTH + 1;

    state_t                state;
    logic [1:0]            idx;
    logic [1:0]            idx_nxt;
    logic [1:0]            n_last;
    logic                  we_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           wdata_q;
    logic [31:0]           lanes;
    logic [31:0]           lanes_fin;
    logic [31:0]           ext_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_wdata_q;
    logic                  mem_we_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_rdata_q;

    logic [2:0]            n_req;
    logic [AW1-1:0]        last_addr;
    logic                  req_err;

    assign n_req     = size_bytes(bus.req_size);
    assign last_addr = {1'b0, bus.req_addr}
                     + AW1'(n_req) - AW1'(1);

    assign req_err =
          (bus.req_size == SIZE_ILLEGAL)
        | ((bus.req_size == SIZE_HALF) & bus.req_addr[0])
        | ((bus.req_size == SIZE_WORD) & (|bus.req_addr[1:0]))
        | (last_addr >= AW1'(MEM_BYTES));

    assign idx_nxt = idx + 2'd1;

    // The last byte arrives during DRAIN; fold it in before extending.
    always_comb begin
        lanes_fin = lanes;
        lanes_fin[{n_last, 3'b000} +: 8] = bus.mem_rdata;
    end

    mem_load_extend u_ext (
        .lanes (lanes_fin),
        .size  (size_q),
        .uns   (uns_q),
        .rdata (ext_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        size_q  <= bus.req_size;
                        base_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        n_last  <= 2'(n_req - 3'd1);
                        lanes   <= 32'd0;
                        idx     <= 2'd0;
                        if (req_err) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            mem_addr_q  <= bus.req_addr;
                            mem_we_q    <= bus.req_we;
                            mem_wdata_q <= bus.req_we ?
                                bus.req_wdata[7:0] : 8'd0;
                        end
                    end
                end
                ISSUE: begin
                    if (!we_q && idx != 2'd0)
                        lanes[{idx - 2'd1, 3'b000} +: 8] <= bus.mem_rdata;
                    if (idx == n_last) begin
                        mem_addr_q  <= '0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= 8'd0;
                        if (we_q) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx         <= idx_nxt;
                        mem_addr_q  <= base_q + ADDR_WIDTH'(idx_nxt);
                        mem_wdata_q <= we_q ?
                            wdata_q[{idx_nxt, 3'b000} +: 8] : 8'd0;
                    end
                end
                DRAIN: begin
                    lanes       <= lanes_fin;
                    rsp_rdata_q <= ext_rdata;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) & ~rst;
    assign bus.rsp_valid = rsp_valid_q & ~rst;
    assign bus.rsp_err   = rsp_err_q & ~rst;
    assign bus.rsp_rdata = rst ? 32'd0 : rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: directed table, random requests against
// a request-level memory model, back-to-back and mid-access reset cases.
module tb_mem_byte_sequencer;
    localparam int MB = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;

    logic [7:0] mem [0:MB-1];
    logic [7:0] shadow [0:MB-1];

    mem_byte_sequencer_if #(.ADDR_WIDTH(32)) bus ();

    mem_byte_sequencer #(
        .ADDR_WIDTH (32),
        .MEM_BYTES  (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Byte memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus.mem_we) wr_count <= wr_count + 1;
        if (bus.mem_we && bus.mem_addr < MB)
            mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
        bus.mem_rdata <= (bus.mem_addr < MB) ?
            mem[bus.mem_addr[3:0]] : 8'h00;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 1;
    endfunction

    function automatic logic model_err(input logic [1:0] s,
                                       input logic [31:0] a);
        longint n = longint'(nbytes(s));
        if (s == 2'd3) return 1'b1;
        if (longint'(a) % n != 0) return 1'b1;
        if (longint'(a) + n - 1 >= MB) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] s,
                                               input logic u,
                                               input logic [31:0] a);
        int     n = nbytes(s);
        longint v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(shadow[int'(a) + i]) << (8 * i);
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    function automatic int model_lat(input logic w, input logic [1:0] s,
                                     input logic e);
        if (e) return 1;
        return w ? nbytes(s) + 1 : nbytes(s) + 2;
    endfunction

    task automatic set_req(input logic w, input logic [1:0] s,
                           input logic u, input logic [31:0] a,
                           input logic [31:0] d);
        bus.req_we       = w;
        bus.req_size     = s;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
    endtask

    task automatic do_req(input logic w, input logic [1:0] s,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d, input logic e_err,
                          input logic [31:0] e_rd, input int e_lat);
        int n = nbytes(s);
        bit done = 0;
        @(negedge clk);
        set_req(w, s, u, a, d);
        bus.req_valid = 1'b1;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (!e_err && k <= n) begin
                chk("mem_addr", bus.mem_addr, a + 32'(k - 1));
                chk("mem_we", 32'(bus.mem_we), 32'(w));
                if (w) chk("mem_wdata", 32'(bus.mem_wdata),
                           32'(d[8*(k-1) +: 8]));
            end else begin
                chk("mem_we_off", 32'(bus.mem_we), 32'd0);
                chk("mem_addr_off", bus.mem_addr, 32'd0);
            end
            if (bus.rsp_valid) begin
                chk("latency", 32'(k), 32'(e_lat));
                chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
                chk("rsp_rdata", bus.rsp_rdata, e_rd);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one");
        end
        if (w && !e_err)
            for (int i = 0; i < n; i++)
                shadow[int'(a) + i] = d[8*i +: 8];
    endtask

    task automatic do_model(input logic w, input logic [1:0] s,
                            input logic u, input logic [31:0] a,
                            input logic [31:0] d);
        logic        e  = model_err(s, a);
        logic [31:0] rd = (e || w) ? 32'd0 : model_load(s, u, a);
        do_req(w, s, u, a, d, e, rd, model_lat(w, s, e));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF, 1'b0, 32'h0, 5};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'd4, 32'h0, 1'b0, 32'hDEADBEEF, 6};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'd6, 32'h0, 1'b0, 32'hFFFFDEAD, 4};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'd6, 32'h0, 1'b0, 32'h0000DEAD, 4};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'd5, 32'h0, 1'b0, 32'hFFFFFFBE, 3};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'd2, 32'h0, 1'b1, 32'h0, 1};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'd3, 32'h0, 1'b1, 32'h0, 1};
        vecs[7]  = '{1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 1'b1, 32'h0, 1};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b1, 32'h0, 1};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'd10, 32'h0, 1'b0, 32'h1A, 3};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'd8, 32'h12348001, 1'b0, 32'h0, 3};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'd8, 32'h0, 1'b0, 32'hFFFF8001, 4};
        vecs[12] = '{1'b1, 2'd0, 1'b0, 32'd11, 32'h55, 1'b1, 32'h0, 1};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0, 1};

        for (int i = 0; i < MB; i++) begin
            mem[i]    = 8'h10 + 8'(i);
            shadow[i] = 8'h10 + 8'(i);
        end
        bus.req_valid = 1'b0;
        set_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);

        foreach (vecs[i])
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                   vecs[i].wdata, vecs[i].err, vecs[i].rdata, vecs[i].lat);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom
                                             : 32'($urandom_range(0, 12));
            do_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), a, $urandom);
        end

        // Back-to-back byte stores with req_valid held high.
        begin
            logic [7:0] bd [3];
            int w0;
            bd[0] = 8'hA1; bd[1] = 8'hB2; bd[2] = 8'hC3;
            @(negedge clk);
            w0 = wr_count;
            set_req(1'b1, 2'd0, 1'b0, 32'd0, {24'd0, bd[0]});
            bus.req_valid = 1'b1;
            chk("b2b_ready0", 32'(bus.req_ready), 32'd1);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                @(negedge clk);
                chk("b2b_issue_ready", 32'(bus.req_ready), 32'd0);
                chk("b2b_we", 32'(bus.mem_we), 32'd1);
                chk("b2b_addr", bus.mem_addr, 32'(k));
                chk("b2b_wdata", 32'(bus.mem_wdata), 32'(bd[k]));
                if (k < 2)
                    set_req(1'b1, 2'd0, 1'b0, 32'(k + 1),
                            {24'd0, bd[k + 1]});
                else
                    bus.req_valid = 1'b0;
                @(negedge clk);
                chk("b2b_resp_ready", 32'(bus.req_ready), 32'd0);
                chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("b2b_rsp_err", 32'(bus.rsp_err), 32'd0);
                if (k < 2) begin
                    @(negedge clk);
                    chk("b2b_next_ready", 32'(bus.req_ready), 32'd1);
                    chk("b2b_next_rsp", 32'(bus.rsp_valid), 32'd0);
                end
            end
            @(negedge clk);
            chk("b2b_done_we", 32'(bus.mem_we), 32'd0);
            chk("b2b_write_count", 32'(wr_count - w0), 32'd3);
            for (int i = 0; i < 3; i++) begin
                chk("b2b_mem", 32'(mem[i]), 32'(bd[i]));
                shadow[i] = bd[i];
            end
        end

        // Reset in the second byte of a word store at 4.
        begin
            logic [7:0] old6, old7;
            old6 = shadow[6];
            old7 = shadow[7];
            @(negedge clk);
            set_req(1'b1, 2'd2, 1'b0, 32'd4, 32'h11223344);
            bus.req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
            chk("rst_c1_addr", bus.mem_addr, 32'd4);
            @(negedge clk);
            chk("rst_c2_addr", bus.mem_addr, 32'd5);
            chk("rst_c2_we", 32'(bus.mem_we), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_c3_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_c3_we", 32'(bus.mem_we), 32'd0);
            chk("rst_c3_addr", bus.mem_addr, 32'd0);
            chk("rst_c3_wdata", 32'(bus.mem_wdata), 32'd0);
            chk("rst_c3_rsp", 32'(bus.rsp_valid), 32'd0);
            rst = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
                chk("rst_idle_ready", 32'(bus.req_ready), 32'd1);
            end
            chk("rst_mem4", 32'(mem[4]), 32'h44);
            chk("rst_mem5", 32'(mem[5]), 32'h33);
            chk("rst_mem6", 32'(mem[6]), 32'(old6));
            chk("rst_mem7", 32'(mem[7]), 32'(old7));
            shadow[4] = 8'h44;
            shadow[5] = 8'h33;
            do_model(1'b0, 2'd2, 1'b0, 32'd4, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
